ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute/write-back stage placed directly after the instruction decoder. It takes the decoded
//  fields alu_sig, oper1, oper2 and dest, reads both source words from an internal 32x32 register
//  file, and applies the 2-bit ALU operation. The result is written back to reg[dest].
//  A 4-state FSM sequences the work, and a start/busy/done handshake connects it to the decoder.
// PARAMETERS
//  WORD_SIZE  32  data word width (bits)
//  MEM_SIZE   32  register-file depth (words)
//  ADDR_LEN   5   register address width; MEM_SIZE == 2**ADDR_LEN
// PORTS
//  clk        in   1          single clock, all state updates on posedge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          one-cycle strobe: the decoded fields below are valid
//  alu_sig    in   2          00 ADD, 01 SUB (oper1-oper2), 10 AND, 11 OR
//  oper1      in   ADDR_LEN   source-A register address
//  oper2      in   ADDR_LEN   source-B register address
//  dest       in   ADDR_LEN   destination register address
//  ld_en      in   1          external register preload enable (bench/boot)
//  ld_addr    in   ADDR_LEN   preload address
//  ld_data    in   WORD_SIZE  preload data
//  busy       out  1          high in READ, EXEC and WRITE
//  done       out  1          one-cycle pulse, coincident with the register-file write
//  result     out  WORD_SIZE  last ALU result, held until the next EXEC
//  zero       out  1          result == 0, registered with result
//  ovf        out  1          signed overflow for ADD/SUB; 0 for AND/OR
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM->IDLE; busy, done, result, zero, ovf = 0; all registers = 0.
//   Reset in mid-operation aborts the operation. No write-back occurs and no done pulse is issued.
//  IDLE : start=1 latches alu_sig/oper1/oper2/dest -> READ. start=0 keeps IDLE.
//  READ : A<=reg[oper1_q], B<=reg[oper2_q] -> EXEC.
//  EXEC : result/zero/ovf <= f(A,B) -> WRITE.
//  WRITE: reg[dest_q]<=result; done=1 for this cycle only -> IDLE.
//  Latency: start sampled at edge 0 -> done high after edge 3; busy high edges 1..3.
//  A new start is accepted at the edge where the FSM is in IDLE, i.e. the edge after done.
//   Sustained throughput is 1 instruction per 4 cycles.
//  start while busy: ignored, and the latched fields are not disturbed. The decoder must hold off.
//  Arithmetic: ADD/SUB are modulo 2**WORD_SIZE; carry/borrow is discarded.
//   ovf = (sign A == sign B') && (sign result != sign A), where B' = B for ADD and ~B for SUB.
//  oper1 == oper2 is legal: both read ports return the same word. dest may equal either source.
//   Register 0 is an ordinary register, not hardwired to zero.
//  ld_en is honoured only in IDLE and ignored otherwise.
//   ld_en and start on the same edge: both take effect. The preload lands first, so READ sees it.
//  Back-to-back dependency: the next instruction's READ sees the previous WRITE, so no forwarding
//   is needed.
//  oper/dest inputs are don't-care outside the start cycle.
// STRUCTURE
//  Shared package: ALU opcode localparams (OP_ADD/OP_SUB/OP_AND/OP_OR), FSM state encodings
//   (IDLE/READ/EXEC/WRITE, 2 bits) and the WORD_SIZE/ADDR_LEN defaults.
//  Sub-module reg_file: MEM_SIZE x WORD_SIZE, two registered read ports, one write port,
//   async active-low clear.
//   ex_stage muxes its write port between the preload path (IDLE) and the write-back (WRITE).
//  The ALU is combinational logic inside ex_stage; result/zero/ovf are registered in EXEC.
// TESTING
//  1 Reset: assert rst_n=0 mid-EXEC -> busy=done=result=zero=ovf=0 at once.
//    After release, reg[dest] is unchanged (still 0).
//  2 ADD: preload r1=5, r2=7; start op=00 oper1=1 oper2=2 dest=3 -> done 3 cycles later,
//    result=12, reg3=12, zero=0.
//  3 SUB/zero: r4=r5=0x1234; op=01 4,5 -> 6 -> result=0, zero=1.
//    Then r7=0 - r1 with r1=1 -> result=0xFFFFFFFF, ovf=0.
//  4 Overflow: r1=0x7FFFFFFF, r2=1, ADD -> 0x80000000, ovf=1.
//    r1=0x80000000, r2=1, SUB -> 0x7FFFFFFF, ovf=1.
//  5 Logic/aliasing: r8=0xF0F0F0F0, r9=0x0FF00FF0. AND 8,9 -> 8 gives 0x00F000F0.
//    Next instruction OR 8,8 -> 10 gives 0x00F000F0, confirming the dependent read.
//  6 Handshake: pulse start in cycles 0 and 1 (second with dest=11) -> one done only;
//    reg11 unchanged.
//    ld_en during busy -> ignored. ld_en+start same edge -> the preloaded value is used.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
//   Shared definitions for the execute/write-back stage: default widths,
//   ALU opcode encodings and the FSM state type.
package ex_stage_pkg;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int DEFAULT_ADDR_LEN  = 5;
  localparam int DEFAULT_MEM_SIZE  = 1 << DEFAULT_ADDR_LEN;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/ex_stage_reg_file.sv
// ex_stage_reg_file
//   MEM_SIZE x WORD_SIZE register file with two registered read ports and
//   one synchronous write port. All words clear on the async active-low reset.
// Ports
//   clk, rst_n        clock, asynchronous active-low clear
//   raddr_a/raddr_b   read addresses, data appears on rdata_a/rdata_b after the edge
//   we/waddr/wdata    write port, takes effect on the clock edge
module ex_stage_reg_file
  import ex_stage_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_LEN  = DEFAULT_ADDR_LEN,
  parameter int MEM_SIZE  = DEFAULT_MEM_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_LEN-1:0]  raddr_a,
  input  logic [ADDR_LEN-1:0]  raddr_b,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b,
  input  logic                 we,
  input  logic [ADDR_LEN-1:0]  waddr,
  input  logic [WORD_SIZE-1:0] wdata
);

  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
  logic [WORD_SIZE-1:0] mem_d [MEM_SIZE];
  logic [WORD_SIZE-1:0] rdata_a_q, rdata_a_d;
  logic [WORD_SIZE-1:0] rdata_b_q, rdata_b_d;

  // Reads return the stored word before any write on the same edge; the
  // stage never reads and writes the array in the same cycle anyway.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
    rdata_a_d = mem_q[raddr_a];
    rdata_b_d = mem_q[raddr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '{default: '0};
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage
//   Execute/write-back stage. On start it latches the decoded fields, reads
//   both sources from the internal register file, runs the 2-bit ALU op and
//   writes the result back to the destination register.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle strobe, fields valid (accepted in IDLE only)
//   alu_sig/oper1/oper2/dest   decoded instruction fields
//   ld_en/ld_addr/ld_data      register preload, honoured in IDLE only
//   busy                       high in READ, EXEC and WRITE
//   done                       high during WRITE, coincident with the write-back
//   result/zero/ovf            registered ALU outputs, updated in EXEC
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_LEN  = DEFAULT_ADDR_LEN,
  parameter int MEM_SIZE  = DEFAULT_MEM_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           alu_sig,
  input  logic [ADDR_LEN-1:0]  oper1,
  input  logic [ADDR_LEN-1:0]  oper2,
  input  logic [ADDR_LEN-1:0]  dest,
  input  logic                 ld_en,
  input  logic [ADDR_LEN-1:0]  ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 zero,
  output logic                 ovf
);

  localparam int MSB = WORD_SIZE - 1;

  state_e               state_q, state_d;
  logic [1:0]           alu_q, alu_d;
  logic [ADDR_LEN-1:0]  oper1_q, oper1_d;
  logic [ADDR_LEN-1:0]  oper2_q, oper2_d;
  logic [ADDR_LEN-1:0]  dest_q, dest_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;

  logic [WORD_SIZE-1:0] src_a, src_b;
  logic [WORD_SIZE-1:0] alu_res;
  logic                 alu_ovf;
  logic                 rf_we;
  logic [ADDR_LEN-1:0]  rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;

  // The read ports follow the latched operands continuously; the values
  // captured at the READ->EXEC edge are the ones the ALU consumes.
  ex_stage_reg_file #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_LEN (ADDR_LEN),
    .MEM_SIZE (MEM_SIZE)
  ) u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr_a(oper1_q),
    .raddr_b(oper2_q),
    .rdata_a(src_a),
    .rdata_b(src_b),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  // Single write port shared between preload (IDLE) and write-back (WRITE).
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state_q == WRITE) begin
      rf_we    = 1'b1;
      rf_waddr = dest_q;
      rf_wdata = result_q;
    end else if (state_q == IDLE && ld_en) begin
      rf_we = 1'b1;
    end
  end

  // Signed overflow: operands of equal effective sign giving a result of the
  // other sign. For SUB the effective B sign is inverted.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_q)
      OP_ADD: begin
        alu_res = src_a + src_b;
        alu_ovf = (src_a[MSB] == src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      OP_SUB: begin
        alu_res = src_a - src_b;
        alu_ovf = (src_a[MSB] != src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      OP_AND:  alu_res = src_a & src_b;
      default: alu_res = src_a | src_b;
    endcase
  end

  // Sequencer: fields latch only in IDLE, so a start while busy is dropped.
  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    oper1_d  = oper1_q;
    oper2_d  = oper2_q;
    dest_d   = dest_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          alu_d   = alu_sig;
          oper1_d = oper1;
          oper2_d = oper2;
          dest_d  = dest;
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        ovf_d    = alu_ovf;
        state_d  = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alu_q    <= '0;
      oper1_q  <= '0;
      oper2_q  <= '0;
      dest_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      oper1_q  <= oper1_d;
      oper2_q  <= oper2_d;
      dest_q   <= dest_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == WRITE);
  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule
